// File: rtl/uart_rx1.sv
// 8N1 UART receiver on clk_48: 2-flop synchronizer, mid-bit start validation,
// bit-centre sampling and a ready/read-strobe handshake with sticky error flags.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to start-bit centre; abort if the line is high again
// DATA  | sampling 8 data bits LSB first at bit centres
// STOP  | sampling the stop bit; publish byte or flag framing error
// BRK   | stop bit was low; wait for the line to return high
module uart_rx1 #(
  parameter int CLKS_PER_BIT = 2500,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int CNT_W        = 12
) (
  input  logic       clk_48,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_r,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             ready_n, fe_n, ov_n;
  logic             rx_m, rx_s;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = rx_data;
    ready_n = rx_ready;
    fe_n    = frame_err;
    ov_n    = overrun;

    // The read strobe clears first so that a same-cycle completion or error wins.
    if (rx_r) begin
      ready_n = 1'b0;
      fe_n    = 1'b0;
      ov_n    = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = 3'd0;
            cnt_n   = BIT_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_n[idx] = rx_s;
          cnt_n        = BIT_LOAD;
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
            data_n  = shift;
            ready_n = 1'b1;
            if (rx_ready && !rx_r) begin
              ov_n = 1'b1;
            end
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      BRK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Synchronizer resets high so leaving reset never looks like a start edge.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_ready  <= ready_n;
      frame_err <= fe_n;
      overrun   <= ov_n;
      rx_busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx1.sv
// Bench for uart_rx1: directed frames plus random traffic, compared every cycle
// against a sample-time model of the receiver.
module tb_uart_rx1;

  localparam int CPB      = 32;
  localparam int HALF     = CPB / 2;
  localparam int STOP_OFF = HALF + 9 * CPB;

  logic       clk_48 = 1'b0;
  logic       rst    = 1'b1;
  logic       rx     = 1'b1;
  logic       rx_r   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, frame_err, overrun, rx_busy;

  int checks = 0;
  int errors = 0;

  always #10 clk_48 = ~clk_48;

  uart_rx1 #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF),
    .CNT_W       (12)
  ) dut (
    .clk_48   (clk_48),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_r     (rx_r),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  // Model: a frame is anchored at t0, the first edge seeing the delayed line low;
  // everything else is decided at fixed offsets from t0.
  int         cyc    = 0;
  logic       d1     = 1'b1;
  logic       d2     = 1'b1;
  int         m_mode = 0;   // 0 idle, 1 inside a frame, 2 waiting out a break
  int         m_t0   = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;

  always @(posedge clk_48) begin
    logic s;
    logic ready_before;
    int   off;
    s = d2;
    if (rst) begin
      d1 = 1'b1; d2 = 1'b1;
      m_mode = 0; m_data = 8'h00;
      m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      d2 = d1;
      d1 = rx;
      ready_before = m_ready;
      if (rx_r) begin
        m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      end
      case (m_mode)
        0: if (!s) begin m_mode = 1; m_t0 = cyc; end
        1: begin
          off = cyc - m_t0;
          if (off == HALF) begin
            if (s) m_mode = 0;
          end else if (off > HALF && off < STOP_OFF) begin
            if ((off - HALF) % CPB == 0) m_byte[(off - HALF) / CPB - 1] = s;
          end else if (off == STOP_OFF) begin
            if (s) begin
              m_data = m_byte;
              if (ready_before && !rx_r) m_ov = 1'b1;
              m_ready = 1'b1;
              m_mode = 0;
            end else begin
              m_fe = 1'b1;
              m_mode = 2;
            end
          end
        end
        default: if (s) m_mode = 0;
      endcase
    end
    cyc++;
  end

  logic rd_once  = 1'b0;
  logic force_rd = 1'b0;
  logic rand_rd  = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_fe    = 1'b0;
  int   rise_cyc = -1;
  int   fe_rises = 0;

  task automatic tick();
    if (rd_once) begin
      rx_r = 1'b1;
      rd_once = 1'b0;
    end else if (force_rd && m_mode == 1 && cyc == m_t0 + STOP_OFF) begin
      rx_r = 1'b1;
    end else if (rand_rd) begin
      rx_r = ($urandom_range(0, 7) == 0);
    end else begin
      rx_r = 1'b0;
    end
    @(negedge clk_48);
    checks++;
    if ({rx_data, rx_ready, frame_err, overrun, rx_busy} !==
        {m_data, m_ready, m_fe, m_ov, (m_mode != 0)}) begin
      errors++;
      $display("FAIL cycle_cmp cyc=%0d got data=%h rdy=%b fe=%b ov=%b busy=%b want data=%h rdy=%b fe=%b ov=%b busy=%b",
               cyc, rx_data, rx_ready, frame_err, overrun, rx_busy,
               m_data, m_ready, m_fe, m_ov, (m_mode != 0));
    end
    if (rx_ready && !prev_ready) rise_cyc = cyc;
    if (frame_err && !prev_fe) fe_rises++;
    prev_ready = rx_ready;
    prev_fe    = frame_err;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic read_pulse();
    rd_once = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == rst_bit) begin
        repeat (CPB / 4) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("midrst_ready", rx_ready, 0);
        check("midrst_busy", rx_busy, 0);
        check("midrst_flags", {frame_err, overrun}, 0);
        check("midrst_data", rx_data, 0);
        rst = 1'b0;
        repeat (CPB - CPB / 4 - 3) tick();
      end else begin
        repeat (CPB) tick();
      end
    end
    rx = stop_bit;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  initial begin
    int p;
    int fe_base;
    logic [7:0] b;
    logic sb;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_data", rx_data, 8'h00);
    check("reset_ready", rx_ready, 0);
    check("reset_fe", frame_err, 0);
    check("reset_ov", overrun, 0);
    check("reset_busy", rx_busy, 0);

    idle(5);
    p = cyc;
    send_byte(8'hA5, 1'b1, -1);
    idle(4);
    check("a5_data", rx_data, 8'hA5);
    check("a5_ready", rx_ready, 1);
    check("a5_latency", rise_cyc - (p + 2), STOP_OFF + 1);
    check("a5_flags", {frame_err, overrun}, 0);

    read_pulse();
    check("read_clears_ready", rx_ready, 0);
    rx = 1'b0;
    repeat (8) tick();
    rx = 1'b1;
    repeat (HALF) tick();
    check("glitch_busy", rx_busy, 0);
    check("glitch_ready", rx_ready, 0);
    check("glitch_fe", frame_err, 0);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_byte(8'h3C, 1'b0, -1);
    idle(CPB);
    check("ferr_set", frame_err, 1);
    check("ferr_ready", rx_ready, 0);
    check("ferr_data", rx_data, 8'h00);
    send_byte(8'h81, 1'b1, -1);
    idle(4);
    check("after_ferr_data", rx_data, 8'h81);
    check("after_ferr_fe_sticky", frame_err, 1);
    read_pulse();
    check("ferr_cleared", {rx_ready, frame_err}, 0);

    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    idle(4);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_ready", rx_ready, 1);
    check("ovr_flag", overrun, 1);
    read_pulse();
    check("ovr_clear_ready", rx_ready, 0);
    check("ovr_clear_ov", overrun, 0);
    check("ovr_clear_fe", frame_err, 0);

    send_byte(8'h33, 1'b1, -1);
    force_rd = 1'b1;
    send_byte(8'h44, 1'b1, -1);
    force_rd = 1'b0;
    idle(4);
    check("samecyc_ready", rx_ready, 1);
    check("samecyc_ov", overrun, 0);
    check("samecyc_data", rx_data, 8'h44);
    read_pulse();

    send_byte(8'hF3, 1'b1, 4);
    idle(CPB);
    check("midrst_tail_ready", rx_ready, 0);
    check("midrst_tail_busy", rx_busy, 0);

    fe_base = fe_rises;
    rx = 1'b0;
    repeat (40 * CPB) tick();
    check("break_fe_count", fe_rises - fe_base, 1);
    check("break_busy", rx_busy, 1);
    rx = 1'b1;
    repeat (4) tick();
    check("break_recover_busy", rx_busy, 0);
    send_byte(8'h5A, 1'b1, -1);
    idle(4);
    check("break_next_data", rx_data, 8'h5A);
    check("break_next_ready", rx_ready, 1);
    read_pulse();

    rand_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      send_byte(b, sb, -1);
      idle($urandom_range(0, 40));
    end
    rand_rd = 1'b0;
    idle(2 * CPB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
